// File: rtl/vectrex_pkg.sv
// Shared types and constants for the vectrex cartridge loader.
//   loader_state_t   : loader FSM state encoding
//   CART_ADDR_W      : cart address width (cart space is 2^CART_ADDR_W bytes)
//   IOCTL_ADDR_W     : width of the hps_io download address
//   SKIP_TIMEOUT_DEF : default clk_sys cycles from download end to end of second reset
//   SKIP_PULSE_DEF   : default second-reset pulse length in clk_sys cycles
package vectrex_pkg;

  localparam int CART_ADDR_W      = 15;
  localparam int IOCTL_ADDR_W     = 25;
  localparam int SKIP_TIMEOUT_DEF = 5000000;
  localparam int SKIP_PULSE_DEF   = 1000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SKIP_WAIT,
    SKIP_RST
  } loader_state_t;

endpackage

// File: rtl/vectrex_addr_mask.sv
// Cart address mask tracker.
// Grows an all-ones-from-LSB mask by one bit for every accepted write whose
// address has a bit outside the current mask, and flags download addresses
// that fall outside the cart space.
//   clk_sys    : system clock
//   rst_n      : asynchronous active-low reset
//   clr_i      : clear mask to zero (download start); wins over wr_i
//   wr_i       : download write strobe, already qualified by the loader state
//   addr_i     : full download byte address
//   in_range_o : addr_i lies inside the cart space (combinational)
//   mask_o     : current cart address mask
module vectrex_addr_mask
  import vectrex_pkg::*;
#(
  parameter int ADDR_W = CART_ADDR_W
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    wr_i,
  input  logic [IOCTL_ADDR_W-1:0] addr_i,
  output logic                    in_range_o,
  output logic [ADDR_W-1:0]       mask_o
);

  logic [ADDR_W-1:0] mask_q, mask_d;
  logic              grow;

  assign in_range_o = (addr_i >> ADDR_W) == '0;

  // At most one bit of growth per write, even if the address jumps several bits.
  assign grow = wr_i & in_range_o & ((addr_i[ADDR_W-1:0] & ~mask_q) != '0);

  always_comb begin
    mask_d = mask_q;
    if (clr_i)
      mask_d = '0;
    else if (grow)
      mask_d = {mask_q[ADDR_W-2:0], 1'b1};
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) mask_q <= '0;
    else        mask_q <= mask_d;
  end

  assign mask_o = mask_q;

endmodule

// File: rtl/vectrex_cart_loader.sv
// Vectrex cartridge loader: turns hps_io ioctl download traffic into cart
// writes, tracks the cart address mask and generates the core reset,
// including the delayed "skip logo" second reset after a download.
//   clk_sys, reset_n              : clock, asynchronous active-low reset
//   ioctl_download/wr/addr/dout   : hps_io download interface
//   skip_logo                     : enable second reset after download
//   user_reset                    : combined user reset request
//   cart_wr/cart_addr/cart_data   : registered cart write port (1 cycle latency)
//   cart_mask                     : cart address mask
//   core_reset                    : registered reset to the vectrex core
//   busy                          : loader is not IDLE
//
// state     | meaning
// IDLE      | no download, no skip sequence pending
// LOAD      | download in progress, writes forwarded to the cart
// SKIP_WAIT | download done, waiting before the second reset
// SKIP_RST  | second reset asserted to the core
module vectrex_cart_loader
  import vectrex_pkg::*;
#(
  parameter int ADDR_W       = CART_ADDR_W,
  parameter int SKIP_TIMEOUT = SKIP_TIMEOUT_DEF,
  parameter int SKIP_PULSE   = SKIP_PULSE_DEF,
  parameter int CNT_W        = 23
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  input  logic                    skip_logo,
  input  logic                    user_reset,
  output logic                    cart_wr,
  output logic [ADDR_W-1:0]       cart_addr,
  output logic [7:0]              cart_data,
  output logic [ADDR_W-1:0]       cart_mask,
  output logic                    core_reset,
  output logic                    busy
);

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_dec;
  logic              dl_q, dl_rise, dl_fall;
  logic              in_range, wr_acc;
  logic              cart_wr_q, core_reset_q, core_reset_d;
  logic [ADDR_W-1:0] cart_addr_q;
  logic [7:0]        cart_data_q;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  assign wr_acc  = (state_q == LOAD) & ioctl_wr & in_range;
  assign cnt_dec = cnt_q - CNT_W'(1);

  vectrex_addr_mask #(.ADDR_W(ADDR_W)) u_mask (
    .clk_sys    (clk_sys),
    .rst_n      (reset_n),
    .clr_i      (dl_rise),
    .wr_i       ((state_q == LOAD) & ioctl_wr),
    .addr_i     (ioctl_addr),
    .in_range_o (in_range),
    .mask_o     (cart_mask)
  );

  // cnt holds the cycles left in the skip sequence, counting the current one,
  // so the sequence spans SKIP_TIMEOUT cycles and SKIP_RST occupies the last
  // SKIP_PULSE of them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD: begin
        if (dl_fall) begin
          if (skip_logo) begin
            state_d = SKIP_WAIT;
            cnt_d   = CNT_W'(SKIP_TIMEOUT);
          end else begin
            state_d = IDLE;
          end
        end
      end
      SKIP_WAIT: begin
        cnt_d = cnt_dec;
        if (cnt_dec <= CNT_W'(SKIP_PULSE)) state_d = SKIP_RST;
      end
      SKIP_RST: begin
        cnt_d = cnt_dec;
        if (cnt_dec == '0) state_d = IDLE;
      end
      default: ;
    endcase
    // A new download aborts whatever was pending.
    if (dl_rise) begin
      state_d = LOAD;
      cnt_d   = '0;
    end
  end

  // Built from state_d so the registered reset lines up with the state.
  assign core_reset_d = user_reset | ioctl_download | (state_d == SKIP_RST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dl_q         <= 1'b0;
      cart_wr_q    <= 1'b0;
      cart_addr_q  <= '0;
      cart_data_q  <= '0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dl_q         <= ioctl_download;
      cart_wr_q    <= wr_acc;
      core_reset_q <= core_reset_d;
      if (wr_acc) begin
        cart_addr_q <= ioctl_addr[ADDR_W-1:0];
        cart_data_q <= ioctl_dout;
      end
    end
  end

  assign cart_wr    = cart_wr_q;
  assign cart_addr  = cart_addr_q;
  assign cart_data  = cart_data_q;
  assign core_reset = core_reset_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_vectrex_cart_loader.sv
module tb_vectrex_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr, skip_logo, user_reset;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        cart_wr, core_reset, busy;
  logic [14:0] cart_addr, cart_mask;
  logic [7:0]  cart_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  vectrex_cart_loader #(
    .ADDR_W(15), .SKIP_TIMEOUT(20), .SKIP_PULSE(4), .CNT_W(23)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .skip_logo      (skip_logo),
    .user_reset     (user_reset),
    .cart_wr        (cart_wr),
    .cart_addr      (cart_addr),
    .cart_data      (cart_data),
    .cart_mask      (cart_mask),
    .core_reset     (core_reset),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Single-cycle write strobe; returns on the negedge after the capturing posedge.
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  logic [24:0] g_addr [4];
  logic [14:0] g_mask [4];

  initial begin
    g_addr[0] = 25'h0000000; g_mask[0] = 15'h0000;
    g_addr[1] = 25'h0000001; g_mask[1] = 15'h0001;
    g_addr[2] = 25'h0000004; g_mask[2] = 15'h0003;
    g_addr[3] = 25'h0004000; g_mask[3] = 15'h0007;

    reset_n = 1'b0;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; skip_logo = 1'b0; user_reset = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;

    // Reset values
    #12;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_cart_wr", cart_wr, 0);
    chk("rst_cart_mask", cart_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cart_addr", cart_addr, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    #1 chk("rel_core_reset_first", core_reset, 1);
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("idle_core_reset", core_reset, 0);
    chk("idle_busy", busy, 0);

    // 1. 8 KB sequential load, skip_logo=0
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("dl_core_reset", core_reset, 1);
    chk("dl_busy", busy, 1);
    chk("dl_mask_clr", cart_mask, 0);
    for (int i = 0; i < 8192; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i) ^ 8'h5A;
      @(negedge clk_sys);
      chk("8k_wr", {8'h0, cart_wr, cart_addr, cart_data},
          {8'h0, 1'b1, 15'(i), 8'(i) ^ 8'h5A});
    end
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("8k_wr_idle", cart_wr, 0);
    chk("8k_mask", cart_mask, 15'h1FFF);
    chk("8k_core_reset_hold", core_reset, 1);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("8k_end_core_reset", core_reset, 0);
    chk("8k_end_busy", busy, 0);
    chk("8k_end_mask", cart_mask, 15'h1FFF);

    // user_reset drives core_reset but leaves the mask alone
    user_reset = 1'b1;
    @(negedge clk_sys);
    chk("ureset_core_reset", core_reset, 1);
    chk("ureset_mask", cart_mask, 15'h1FFF);
    user_reset = 1'b0;
    @(negedge clk_sys);
    chk("ureset_release", core_reset, 0);

    // writes outside LOAD are ignored
    wr_byte(25'h0000002, 8'h33);
    chk("idle_wr_ignored", cart_wr, 0);
    chk("idle_wr_mask", cart_mask, 15'h1FFF);

    // 2. Mask growth
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("grow_clr", cart_mask, 0);
    for (int i = 0; i < 4; i++) begin
      wr_byte(g_addr[i], 8'(i + 1));
      chk("grow_mask", cart_mask, g_mask[i]);
      chk("grow_wr", cart_wr, 1);
      chk("grow_addr", cart_addr, g_addr[i][14:0]);
      @(negedge clk_sys);
    end

    // 5. Out of range
    wr_byte(25'h0008000, 8'hAA);
    chk("oor_wr", cart_wr, 0);
    chk("oor_mask", cart_mask, 15'h0007);
    wr_byte(25'h1000001, 8'hBB);
    chk("oor_hi_wr", cart_wr, 0);
    chk("oor_hi_mask", cart_mask, 15'h0007);

    // 3. Skip logo: 16 low, 4 high, then low and idle
    ioctl_download = 1'b0;
    skip_logo = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk_sys);
      skip_logo = 1'b0;
      chk("skip_core_reset", core_reset, (k >= 16 && k <= 19) ? 1 : 0);
      chk("skip_busy", busy, (k <= 19) ? 1 : 0);
    end
    chk("skip_mask_kept", cart_mask, 15'h0007);

    // 4. Abort a pending skip sequence at cnt=10
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    wr_byte(25'h0000001, 8'h11);
    chk("abort_pre_mask", cart_mask, 15'h0001);
    ioctl_download = 1'b0;
    skip_logo = 1'b1;
    repeat (11) @(negedge clk_sys);
    chk("abort_wait_busy", busy, 1);
    chk("abort_wait_core_reset", core_reset, 0);
    ioctl_download = 1'b1;
    skip_logo = 1'b0;
    @(negedge clk_sys);
    chk("abort_core_reset", core_reset, 1);
    chk("abort_mask", cart_mask, 0);
    chk("abort_busy", busy, 1);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk_sys);
      chk("abort_hold", core_reset, 1);
    end
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("abort_end_busy", busy, 0);
    for (int j = 0; j < 8; j++) begin
      chk("abort_no_pulse", core_reset, 0);
      @(negedge clk_sys);
    end

    // 6. Async reset mid-LOAD
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    wr_byte(25'h0000123, 8'h77);
    chk("arst_pre_wr", cart_wr, 1);
    chk("arst_pre_mask", cart_mask, 15'h0001);
    #2;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("arst_cart_wr", cart_wr, 0);
    chk("arst_mask", cart_mask, 0);
    chk("arst_core_reset", core_reset, 1);
    chk("arst_busy", busy, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("arst_post_busy", busy, 0);
    chk("arst_post_core_reset", core_reset, 0);
    chk("arst_post_wr", cart_wr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
